// File: rtl/irq_pkg.sv
// Shared constants, register-select decode and vector-word packing for the
// interrupt controller.
package irq_pkg;

  localparam int IRQ_MAX_SRC   = 31;
  localparam int VEC_VALID_BIT = 31;
  localparam int VEC_IDX_W     = 5;

  // Register offsets; the encoding is what the read mux and claim logic switch on.
  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_MODE    = 3'd2,
    REG_VECTOR  = 3'd3,
    REG_NONE    = 3'd7
  } reg_sel_e;

  // Several selects may be asserted at once; reads resolve pending > enable > mode > vector.
  function automatic reg_sel_e decode_sel(input logic pending_sel, input logic enable_sel,
                                          input logic mode_sel, input logic vector_sel);
    if (pending_sel)     return REG_PENDING;
    else if (enable_sel) return REG_ENABLE;
    else if (mode_sel)   return REG_MODE;
    else if (vector_sel) return REG_VECTOR;
    else                 return REG_NONE;
  endfunction

  function automatic logic [31:0] vector_word(input logic valid, input logic [VEC_IDX_W-1:0] idx);
    logic [31:0] w;
    w = '0;
    if (valid) begin
      w[VEC_VALID_BIT]    = 1'b1;
      w[VEC_IDX_W-1:0]    = idx;
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending-and-enabled sources.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   req,
  output logic                 valid,
  output logic [VEC_IDX_W-1:0] idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = VEC_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge/level capture into a pending
// register, per-source enable, registered CPU line and claim-on-read vector.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               AS_L,
  input  logic               WE_L,
  input  logic               pending_select,
  input  logic               enable_select,
  input  logic               mode_select,
  input  logic               vector_select,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic [NUM_SRC-1:0] src_irq,
  output logic               cpu_irq
);

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               cpu_irq_q, cpu_irq_d;

  logic [NUM_SRC-1:0]   set_vec;
  logic [NUM_SRC-1:0]   clear_vec;
  logic [NUM_SRC-1:0]   claim_mask;
  logic [NUM_SRC-1:0]   wr_data;
  logic                 prio_valid;
  logic [VEC_IDX_W-1:0] prio_idx;
  logic                 bus_rd, bus_wr, claim;
  reg_sel_e             rd_sel;
  logic                 unused_data_hi;

  assign wr_data        = data_in[NUM_SRC-1:0];
  assign unused_data_hi = ^data_in[31:NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_set
    assign set_vec[gi] = mode_q[gi] ? (src_irq[gi] & ~src_q[gi]) : src_irq[gi];
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (pending_q & enable_q),
    .valid (prio_valid),
    .idx   (prio_idx)
  );

  // Only edge sources are acknowledged by the claim; level sources wait for their device.
  assign claim_mask = (NUM_SRC'(1) << prio_idx) & mode_q;

  always_comb begin
    bus_rd = ~AS_L & WE_L;
    bus_wr = ~AS_L & ~WE_L;
    rd_sel = decode_sel(pending_select, enable_select, mode_select, vector_select);
    claim  = bus_rd && (rd_sel == REG_VECTOR) && prio_valid;

    clear_vec = '0;
    if (bus_wr && pending_select) clear_vec = wr_data;
    if (claim)                    clear_vec = clear_vec | claim_mask;

    // OR-ing set last means a fresh event survives a same-cycle clear.
    pending_d = (pending_q & ~clear_vec) | set_vec;
    enable_d  = (bus_wr && enable_select) ? wr_data : enable_q;
    mode_d    = (bus_wr && mode_select) ? wr_data : mode_q;
    src_d     = src_irq;
    cpu_irq_d = |(pending_q & enable_q);

    data_out_d = data_out_q;
    if (bus_rd) begin
      case (rd_sel)
        REG_PENDING: data_out_d = 32'(pending_q);
        REG_ENABLE:  data_out_d = 32'(enable_q);
        REG_MODE:    data_out_d = 32'(mode_q);
        REG_VECTOR:  data_out_d = vector_word(prio_valid, prio_idx);
        default:     data_out_d = data_out_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      src_q      <= '0;
      data_out_q <= '0;
      cpu_irq_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      src_q      <= src_d;
      data_out_q <= data_out_d;
      cpu_irq_q  <= cpu_irq_d;
    end
  end

  assign data_out = data_out_q;
  assign cpu_irq  = cpu_irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register table plus hand-written interrupt sequences.
module tb_irq_controller;

  localparam int NUM_SRC = 8;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_PEND = 4'b0001;
  localparam logic [3:0] S_EN   = 4'b0010;
  localparam logic [3:0] S_MODE = 4'b0100;
  localparam logic [3:0] S_VEC  = 4'b1000;

  localparam int OP_WR   = 0;
  localparam int OP_RD   = 1;
  localparam int OP_IDLE = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               AS_L = 1'b1;
  logic               WE_L = 1'b1;
  logic               pending_select = 1'b0;
  logic               enable_select = 1'b0;
  logic               mode_select = 1'b0;
  logic               vector_select = 1'b0;
  logic [31:0]        data_in = '0;
  logic [31:0]        data_out;
  logic [NUM_SRC-1:0] src_irq = '0;
  logic               cpu_irq;

  irq_controller #(.NUM_SRC(NUM_SRC)) dut (
    .clk            (clk),
    .reset          (reset),
    .AS_L           (AS_L),
    .WE_L           (WE_L),
    .pending_select (pending_select),
    .enable_select  (enable_select),
    .mode_select    (mode_select),
    .vector_select  (vector_select),
    .data_in        (data_in),
    .data_out       (data_out),
    .src_irq        (src_irq),
    .cpu_irq        (cpu_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    int          op;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[16];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input bit wr, input bit strobe, input logic [3:0] sel, input logic [31:0] d);
    AS_L = ~strobe;
    WE_L = ~wr;
    {vector_select, mode_select, enable_select, pending_select} = sel;
    data_in = d;
  endtask

  task automatic idle_bus();
    drive_bus(1'b0, 1'b0, S_NONE, 32'h0);
  endtask

  task automatic wr(input logic [3:0] sel, input logic [31:0] d);
    drive_bus(1'b1, 1'b1, sel, d);
    step();
    idle_bus();
    $display("wr   sel=%b data=0x%08h", sel, d);
  endtask

  // Expected value is queued with the stimulus and popped once data_out has updated.
  task automatic rd(input logic [3:0] sel, input logic [31:0] exp, input string name, input bit strobe = 1'b1);
    sb_t e;
    sb_q.push_back('{name: name, exp: exp});
    drive_bus(1'b0, strobe, sel, 32'h0);
    step();
    idle_bus();
    e = sb_q.pop_front();
    chk(e.name, data_out, e.exp);
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    src_irq = src_irq | m;
    step();
    src_irq = src_irq & ~m;
  endtask

  initial begin
    tbl[0]  = '{OP_WR,   S_EN,          32'hFFFF_FF5A, 32'h0,  "wr_en"};
    tbl[1]  = '{OP_RD,   S_EN,          32'h0,         32'h5A, "en_upper_bits_zero"};
    tbl[2]  = '{OP_WR,   S_MODE,        32'h0000_00C3, 32'h0,  "wr_mode"};
    tbl[3]  = '{OP_RD,   S_MODE,        32'h0,         32'hC3, "mode_readback"};
    tbl[4]  = '{OP_IDLE, S_EN,          32'h0,         32'hC3, "hold_no_strobe"};
    tbl[5]  = '{OP_RD,   S_NONE,        32'h0,         32'hC3, "hold_no_select"};
    tbl[6]  = '{OP_WR,   S_EN | S_MODE, 32'h0000_000F, 32'h0,  "wr_multi"};
    tbl[7]  = '{OP_WR,   S_MODE,        32'h0000_0030, 32'h0,  "wr_mode2"};
    tbl[8]  = '{OP_RD,   S_EN | S_MODE, 32'h0,         32'h0F, "prio_en_over_mode"};
    tbl[9]  = '{OP_RD,   S_MODE | S_VEC,32'h0,         32'h30, "prio_mode_over_vec"};
    tbl[10] = '{OP_RD,   S_PEND | S_EN, 32'h0,         32'h00, "prio_pend_over_en"};
    tbl[11] = '{OP_WR,   S_VEC,         32'hFFFF_FFFF, 32'h0,  "wr_vec_ignored"};
    tbl[12] = '{OP_RD,   S_VEC,         32'h0,         32'h00, "vec_empty"};
    tbl[13] = '{OP_WR,   S_EN | S_MODE, 32'h0,         32'h0,  "wr_clear"};
    tbl[14] = '{OP_RD,   S_EN,          32'h0,         32'h00, "en_cleared"};
    tbl[15] = '{OP_RD,   S_MODE,        32'h0,         32'h00, "mode_cleared"};

    // Reset defaults
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_cpu_irq", {31'h0, cpu_irq}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    rd(S_PEND, 32'h0, "rst_pending");
    rd(S_EN,   32'h0, "rst_enable");
    rd(S_MODE, 32'h0, "rst_mode");
    rd(S_VEC,  32'h0, "rst_vector");

    // Register access table
    for (int i = 0; i < 16; i++) begin
      case (tbl[i].op)
        OP_WR:   wr(tbl[i].sel, tbl[i].data);
        OP_RD:   rd(tbl[i].sel, tbl[i].exp, tbl[i].name);
        default: rd(tbl[i].sel, tbl[i].exp, tbl[i].name, 1'b0);
      endcase
    end

    // Level source on the timer input
    wr(S_MODE, 32'h00);
    wr(S_EN, 32'h01);
    src_irq[0] = 1'b1;
    step();
    chk("lvl_cpu_irq_edge1", {31'h0, cpu_irq}, 32'h0);
    step();
    chk("lvl_cpu_irq_edge2", {31'h0, cpu_irq}, 32'h1);
    rd(S_VEC, 32'h8000_0000, "lvl_vector");
    rd(S_PEND, 32'h01, "lvl_pending_after_claim");
    wr(S_PEND, 32'h01);
    rd(S_PEND, 32'h01, "lvl_w1c_while_high");
    src_irq[0] = 1'b0;
    wr(S_PEND, 32'h01);
    rd(S_PEND, 32'h00, "lvl_w1c_after_drop");
    chk("lvl_cpu_irq_low", {31'h0, cpu_irq}, 32'h0);

    // Edge source with claim
    wr(S_MODE, 32'h08);
    wr(S_EN, 32'h08);
    pulse(8'h08);
    rd(S_PEND, 32'h08, "edge_pending");
    chk("edge_cpu_irq_high", {31'h0, cpu_irq}, 32'h1);
    rd(S_VEC, 32'h8000_0003, "edge_vector");
    chk("edge_cpu_irq_claim_edge", {31'h0, cpu_irq}, 32'h1);
    step();
    chk("edge_cpu_irq_dropped", {31'h0, cpu_irq}, 32'h0);
    rd(S_PEND, 32'h00, "edge_pending_claimed");

    // Priority with back-to-back claims
    wr(S_EN, 32'hFF);
    wr(S_MODE, 32'h24);
    pulse(8'h24);
    rd(S_VEC, 32'h8000_0002, "prio_first");
    rd(S_VEC, 32'h8000_0005, "prio_second");
    rd(S_VEC, 32'h0000_0000, "prio_empty");

    // Set beats clear in the same cycle
    wr(S_MODE, 32'h10);
    pulse(8'h10);
    rd(S_PEND, 32'h10, "simul_pending_before");
    src_irq[4] = 1'b1;
    wr(S_PEND, 32'h10);
    src_irq[4] = 1'b0;
    rd(S_PEND, 32'h10, "simul_w1c_vs_edge");
    src_irq[4] = 1'b1;
    rd(S_VEC, 32'h8000_0004, "simul_claim_vector");
    src_irq[4] = 1'b0;
    rd(S_PEND, 32'h10, "simul_claim_vs_edge");
    rd(S_VEC, 32'h8000_0004, "simul_claim_again");
    rd(S_PEND, 32'h00, "simul_cleared");

    // Masking, then reset during a vector read
    wr(S_EN, 32'h00);
    wr(S_MODE, 32'h02);
    pulse(8'h02);
    rd(S_PEND, 32'h02, "mask_pending_kept");
    chk("mask_cpu_irq_low", {31'h0, cpu_irq}, 32'h0);
    rd(S_VEC, 32'h0, "mask_vector_empty");
    wr(S_EN, 32'h02);
    chk("mask_cpu_irq_same_edge", {31'h0, cpu_irq}, 32'h0);
    step();
    chk("mask_cpu_irq_reenabled", {31'h0, cpu_irq}, 32'h1);
    reset = 1'b1;
    drive_bus(1'b0, 1'b1, S_VEC, 32'h0);
    step();
    idle_bus();
    reset = 1'b0;
    chk("rst_mid_data_out", data_out, 32'h0);
    chk("rst_mid_cpu_irq", {31'h0, cpu_irq}, 32'h0);
    rd(S_PEND, 32'h00, "rst_mid_pending");
    rd(S_EN, 32'h00, "rst_mid_enable");
    rd(S_MODE, 32'h00, "rst_mid_mode");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
